drum_step_sequencer: RTL and testbench

Tempo-driven step sequencer that schedules the one-shot drum voices (kick, snare, hat, …) from a writable pattern memory. It counts sample ticks, advances through the steps, and drives one gated trigger line per voice into the voices' envelope trigger inputs. It sits between the PS-side control registers and the voice bank, and is the single source of trigger timing for the whole drum section.

---
 rtl/drum_step_sequencer_if.sv | 15 +
 rtl/drum_step_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_drum_step_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/drum_step_sequencer_if.sv
// Pattern-memory configuration bus for drum_step_sequencer.
// Write handshake: a row write is accepted on every rising clk where cfg_we
// is high. There is no ready signal because the sink never stalls, so the
// master may present a new write on every cycle.
interface drum_step_sequencer_if #(
    parameter int NUM_VOICES = 4,
    parameter int NUM_STEPS  = 16
);
    logic                         cfg_we;
    logic [$clog2(NUM_STEPS)-1:0] cfg_step;
    logic [NUM_VOICES-1:0]        cfg_pattern;

    modport master (output cfg_we, cfg_step, cfg_pattern);
    modport slave  (input  cfg_we, cfg_step, cfg_pattern);
endinterface

// File: rtl/drum_step_sequencer.sv
// Tempo-driven drum step sequencer: counts sample ticks, walks a writable
// pattern memory and drives one gated trigger line per voice.
// Optional build macro DRUM_SEQ_SWING_EN adds a swing[7:0] input that delays
// odd steps by (step_len*swing)>>8 samples while keeping the step period.
// seq_state / gate_state expose the top FSM and per-voice gate FSMs.
module drum_step_sequencer #(
    parameter int NUM_VOICES = 4,
    parameter int NUM_STEPS  = 16,
    parameter int TICK_BITS  = 20,
    parameter int GATE_BITS  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_tick,
    input  logic                         run,
    input  logic [TICK_BITS-1:0]         step_len,
    input  logic [GATE_BITS-1:0]         gate_len,
`ifdef DRUM_SEQ_SWING_EN
    input  logic [7:0]                   swing,
`endif
    drum_step_sequencer_if.slave         cfg,
    input  logic [NUM_VOICES-1:0]        manual_trig,
    output logic [NUM_VOICES-1:0]        trig_out,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic                         step_strobe,
    output logic [1:0]                   seq_state,
    output logic [2*NUM_VOICES-1:0]      gate_state
);
    localparam int STEP_W = $clog2(NUM_STEPS);
    // One spare bit so a swung count (len-1+delay) never wraps.
    localparam int CNT_W  = TICK_BITS + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_RUN = 2'd2} seq_state_t;
    typedef enum logic [1:0] {G_OFF = 2'd0, G_ON = 2'd1, G_GAP = 2'd2} gate_state_t;

    seq_state_t            state;
    logic [CNT_W-1:0]      tick_cnt;
    logic [NUM_VOICES-1:0] pattern [NUM_STEPS];

    logic [CNT_W-1:0]      len_eff;
    logic [GATE_BITS-1:0]  gate_eff;
    logic [CNT_W-1:0]      target;
    logic [STEP_W-1:0]     fire_idx;
    logic                  boundary;
    logic                  step_fire;
    logic [NUM_VOICES-1:0] hits;

    assign len_eff  = (step_len == '0) ? CNT_W'(1) : {1'b0, step_len};
    assign gate_eff = (gate_len == '0) ? GATE_BITS'(1) : gate_len;
    assign fire_idx = (state == S_START) ? '0 : step_idx + STEP_W'(1);

`ifdef DRUM_SEQ_SWING_EN
    logic [CNT_W+7:0] swing_prod;
    logic [CNT_W-1:0] swing_dly;
    assign swing_prod = {8'd0, len_eff} * {{CNT_W{1'b0}}, swing};
    assign swing_dly  = CNT_W'(swing_prod >> 8);

    // Odd steps land late by swing_dly; the following even step comes early
    // by the same amount so the pair still spans two nominal steps.
    always_comb begin
        target = len_eff - CNT_W'(1);
        if (fire_idx[0])
            target = len_eff - CNT_W'(1) + swing_dly;
        else
            target = len_eff - CNT_W'(1) - swing_dly;
    end
`else
    // Straight grid: every step is len_eff ticks long.
    always_comb begin
        target = len_eff - CNT_W'(1);
    end
`endif

    // >= rather than == so a shortened step_len fires on the next tick.
    assign boundary  = (tick_cnt >= target);
    assign step_fire = sample_tick && run &&
                       ((state == S_START) || ((state == S_RUN) && boundary));
    // Pattern is read before this cycle's write lands, so a same-cycle write
    // to the firing row only affects the next pass.
    assign hits      = manual_trig | (step_fire ? pattern[fire_idx] : '0);
    assign seq_state = state;

    // Pattern register file, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STEPS; i++) pattern[i] <= '0;
        end else if (cfg.cfg_we) begin
            pattern[cfg.cfg_step] <= cfg.cfg_pattern;
        end
    end

    // Top sequencer FSM: step counter, step index and strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            tick_cnt    <= '0;
            step_idx    <= '0;
            step_strobe <= 1'b0;
        end else begin
            step_strobe <= step_fire;
            case (state)
                S_IDLE: begin
                    tick_cnt <= '0;
                    step_idx <= '0;
                    if (run) state <= S_START;
                end
                S_START: begin
                    if (!run) begin
                        state <= S_IDLE;
                    end else if (sample_tick) begin
                        state    <= S_RUN;
                        tick_cnt <= '0;
                        step_idx <= '0;
                    end
                end
                S_RUN: begin
                    // Stop takes priority over a coinciding step boundary.
                    if (!run) begin
                        state    <= S_IDLE;
                        tick_cnt <= '0;
                        step_idx <= '0;
                    end else if (sample_tick) begin
                        if (boundary) begin
                            tick_cnt <= '0;
                            step_idx <= fire_idx;
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        gate_state_t          g_state;
        logic [GATE_BITS-1:0] g_cnt;
        logic                 trig_q;

        assign trig_out[v]          = trig_q;
        assign gate_state[2*v +: 2] = g_state;

        // Per-voice gate: a hit during ON drops the line for one tick so
        // downstream edge detectors see a fresh rising edge.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                g_state <= G_OFF;
                g_cnt   <= '0;
                trig_q  <= 1'b0;
            end else begin
                case (g_state)
                    G_OFF: begin
                        if (hits[v]) begin
                            g_state <= G_ON;
                            g_cnt   <= gate_eff;
                            trig_q  <= 1'b1;
                        end
                    end
                    G_ON: begin
                        if (hits[v]) begin
                            g_state <= G_GAP;
                            trig_q  <= 1'b0;
                        end else if (sample_tick) begin
                            if (g_cnt < GATE_BITS'(2)) begin
                                g_state <= G_OFF;
                                g_cnt   <= '0;
                                trig_q  <= 1'b0;
                            end else begin
                                g_cnt <= g_cnt - GATE_BITS'(1);
                            end
                        end
                    end
                    G_GAP: begin
                        if (sample_tick) begin
                            g_state <= G_ON;
                            g_cnt   <= gate_eff;
                            trig_q  <= 1'b1;
                        end
                    end
                    default: begin
                        g_state <= G_OFF;
                        trig_q  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_drum_step_sequencer.sv
// Directed bench for drum_step_sequencer with hand-derived expectations.
module tb_drum_step_sequencer;
    localparam int NV = 4;
    localparam int NS = 16;
    localparam int TB = 20;
    localparam int GB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_tick = 1'b0;
    logic          run = 1'b0;
    logic [TB-1:0] step_len = '0;
    logic [GB-1:0] gate_len = '0;
    logic [NV-1:0] manual_trig = '0;
    logic [NV-1:0] trig_out;
    logic [3:0]    step_idx;
    logic          step_strobe;
    logic [1:0]    seq_state;
    logic [2*NV-1:0] gate_state;
`ifdef DRUM_SEQ_SWING_EN
    logic [7:0]    swing = 8'd0;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    drum_step_sequencer_if #(.NUM_VOICES(NV), .NUM_STEPS(NS)) cfg_if ();

    drum_step_sequencer #(
        .NUM_VOICES(NV), .NUM_STEPS(NS), .TICK_BITS(TB), .GATE_BITS(GB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_tick(sample_tick),
        .run(run),
        .step_len(step_len),
        .gate_len(gate_len),
`ifdef DRUM_SEQ_SWING_EN
        .swing(swing),
`endif
        .cfg(cfg_if),
        .manual_trig(manual_trig),
        .trig_out(trig_out),
        .step_idx(step_idx),
        .step_strobe(step_strobe),
        .seq_state(seq_state),
        .gate_state(gate_state)
    );

    // Clock
    always #5 clk = ~clk;

    // One clock cycle with sample_tick = t; returns 1 time unit after the edge.
    task automatic cyc(input logic t);
        sample_tick = t;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
    endtask

    task automatic write_row(input int r, input logic [NV-1:0] p);
        cfg_if.cfg_we      = 1'b1;
        cfg_if.cfg_step    = 4'(r);
        cfg_if.cfg_pattern = p;
        cyc(1'b0);
        cfg_if.cfg_we      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        vec_cnt++;
        if (trig_out !== 4'b0000) begin err_cnt++; $display("FAIL reset_trig got %b exp 0000", trig_out); end
        vec_cnt++;
        if (step_idx !== 4'd0) begin err_cnt++; $display("FAIL reset_idx got %0d exp 0", step_idx); end
        vec_cnt++;
        if (step_strobe !== 1'b0) begin err_cnt++; $display("FAIL reset_strobe got %b exp 0", step_strobe); end
        vec_cnt++;
        if (seq_state !== 2'd0) begin err_cnt++; $display("FAIL reset_state got %0d exp 0", seq_state); end
        vec_cnt++;
        if (gate_state !== 8'd0) begin err_cnt++; $display("FAIL reset_gates got %h exp 00", gate_state); end
        rst = 1'b0;
        cyc(1'b0);
    endtask

    task automatic test_pattern();
        logic [3:0] exp_trig;
        logic [3:0] exp_idx;
        logic       exp_strobe;
        int ks;
        write_row(0, 4'b0001);
        write_row(4, 4'b0010);
        step_len = 4;
        gate_len = 2;
        run = 1'b1;
        cyc(1'b0);
        for (int k = 0; k < 68; k++) begin
            cyc(1'b1);
            ks = k % 64;
            exp_trig   = (ks < 2) ? 4'b0001 : ((ks == 16 || ks == 17) ? 4'b0010 : 4'b0000);
            exp_strobe = (k % 4 == 0);
            exp_idx    = 4'((k / 4) % 16);
            vec_cnt++;
            if (trig_out !== exp_trig) begin err_cnt++; $display("FAIL pattern_trig k=%0d got %b exp %b", k, trig_out, exp_trig); end
            vec_cnt++;
            if (step_strobe !== exp_strobe) begin err_cnt++; $display("FAIL pattern_strobe k=%0d got %b exp %b", k, step_strobe, exp_strobe); end
            vec_cnt++;
            if (step_idx !== exp_idx) begin err_cnt++; $display("FAIL pattern_idx k=%0d got %0d exp %0d", k, step_idx, exp_idx); end
            cyc(1'b0);
            if (k % 16 == 0) begin
                vec_cnt++;
                if (step_strobe !== 1'b0) begin err_cnt++; $display("FAIL pattern_strobe_width k=%0d got %b exp 0", k, step_strobe); end
            end
        end
        run = 1'b0;
        cyc(1'b0);
        vec_cnt++;
        if (seq_state !== 2'd0) begin err_cnt++; $display("FAIL pattern_stop_state got %0d exp 0", seq_state); end
        write_row(0, 4'b0000);
        write_row(4, 4'b0000);
    endtask

    task automatic test_retrigger();
        logic [3:0] exp_trig;
        for (int r = 0; r < NS; r++) write_row(r, 4'b0001);
        step_len = 4;
        gate_len = 10;
        run = 1'b1;
        cyc(1'b0);
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1);
            exp_trig = (k > 0 && k % 4 == 0) ? 4'b0000 : 4'b0001;
            vec_cnt++;
            if (trig_out !== exp_trig) begin err_cnt++; $display("FAIL retrig_trig k=%0d got %b exp %b", k, trig_out, exp_trig); end
            cyc(1'b0);
        end
        run = 1'b0;
        cyc(1'b0);
        vec_cnt++;
        if (trig_out !== 4'b0001) begin err_cnt++; $display("FAIL retrig_gate_survives_stop got %b exp 0001", trig_out); end
        for (int r = 0; r < NS; r++) write_row(r, 4'b0000);
        for (int i = 0; i < 12; i++) begin cyc(1'b1); cyc(1'b0); end
        vec_cnt++;
        if (trig_out !== 4'b0000) begin err_cnt++; $display("FAIL retrig_drain got %b exp 0000", trig_out); end
    endtask

    task automatic test_manual();
        logic [3:0] exp_trig;
        run = 1'b0;
        gate_len = 3;
        manual_trig = 4'b0100;
        cyc(1'b0);
        manual_trig = 4'b0000;
        vec_cnt++;
        if (trig_out !== 4'b0100) begin err_cnt++; $display("FAIL manual_rise got %b exp 0100", trig_out); end
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1);
            exp_trig = (i < 3) ? 4'b0100 : 4'b0000;
            vec_cnt++;
            if (trig_out !== exp_trig) begin err_cnt++; $display("FAIL manual_gate tick=%0d got %b exp %b", i, trig_out, exp_trig); end
            vec_cnt++;
            if (step_idx !== 4'd0) begin err_cnt++; $display("FAIL manual_idx tick=%0d got %0d exp 0", i, step_idx); end
            vec_cnt++;
            if (step_strobe !== 1'b0) begin err_cnt++; $display("FAIL manual_strobe tick=%0d got %b exp 0", i, step_strobe); end
            cyc(1'b0);
        end
    endtask

    task automatic test_run_drop();
        write_row(0, 4'b0001);
        step_len = 2;
        gate_len = 1;
        run = 1'b1;
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        vec_cnt++;
        if (step_idx !== 4'd1) begin err_cnt++; $display("FAIL drop_pre_idx got %0d exp 1", step_idx); end
        cyc(1'b1);
        run = 1'b0;
        cyc(1'b1);
        vec_cnt++;
        if (step_strobe !== 1'b0) begin err_cnt++; $display("FAIL drop_strobe got %b exp 0", step_strobe); end
        vec_cnt++;
        if (step_idx !== 4'd0) begin err_cnt++; $display("FAIL drop_idx got %0d exp 0", step_idx); end
        vec_cnt++;
        if (seq_state !== 2'd0) begin err_cnt++; $display("FAIL drop_state got %0d exp 0", seq_state); end
        run = 1'b1;
        cyc(1'b0);
        vec_cnt++;
        if (seq_state !== 2'd1) begin err_cnt++; $display("FAIL rerun_state got %0d exp 1", seq_state); end
        cyc(1'b1);
        vec_cnt++;
        if (step_strobe !== 1'b1) begin err_cnt++; $display("FAIL rerun_strobe got %b exp 1", step_strobe); end
        vec_cnt++;
        if (trig_out !== 4'b0001) begin err_cnt++; $display("FAIL rerun_trig got %b exp 0001", trig_out); end
        run = 1'b0;
        cyc(1'b0);
        cyc(1'b1);
        write_row(0, 4'b0000);
    endtask

    task automatic test_zero_len();
        logic [3:0] exp_idx;
        write_row(1, 4'b1000);
        step_len = 0;
        gate_len = 0;
        run = 1'b1;
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0);
        cfg_if.cfg_we      = 1'b1;
        cfg_if.cfg_step    = 4'd1;
        cfg_if.cfg_pattern = 4'b0000;
        cyc(1'b1);
        cfg_if.cfg_we = 1'b0;
        vec_cnt++;
        if (trig_out !== 4'b1000) begin err_cnt++; $display("FAIL zero_old_row got %b exp 1000", trig_out); end
        vec_cnt++;
        if (step_idx !== 4'd1) begin err_cnt++; $display("FAIL zero_idx1 got %0d exp 1", step_idx); end
        cyc(1'b0);
        for (int k = 2; k < 18; k++) begin
            cyc(1'b1);
            exp_idx = 4'(k % 16);
            vec_cnt++;
            if (step_idx !== exp_idx) begin err_cnt++; $display("FAIL zero_idx k=%0d got %0d exp %0d", k, step_idx, exp_idx); end
            vec_cnt++;
            if (step_strobe !== 1'b1) begin err_cnt++; $display("FAIL zero_strobe k=%0d got %b exp 1", k, step_strobe); end
            vec_cnt++;
            if (trig_out !== 4'b0000) begin err_cnt++; $display("FAIL zero_trig k=%0d got %b exp 0000", k, trig_out); end
            cyc(1'b0);
        end
        run = 1'b0;
        cyc(1'b0);
    endtask

    task automatic test_len_change();
        logic       exp_strobe;
        logic [3:0] exp_idx;
        step_len = 8;
        gate_len = 1;
        run = 1'b1;
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0);
        for (int k = 1; k <= 10; k++) begin
            if (k == 6) step_len = 4;
            cyc(1'b1);
            exp_strobe = (k == 6 || k == 10);
            exp_idx    = (k < 6) ? 4'd0 : ((k < 10) ? 4'd1 : 4'd2);
            vec_cnt++;
            if (step_strobe !== exp_strobe) begin err_cnt++; $display("FAIL lenchg_strobe k=%0d got %b exp %b", k, step_strobe, exp_strobe); end
            vec_cnt++;
            if (step_idx !== exp_idx) begin err_cnt++; $display("FAIL lenchg_idx k=%0d got %0d exp %0d", k, step_idx, exp_idx); end
            cyc(1'b0);
        end
        run = 1'b0;
        cyc(1'b0);
    endtask

`ifdef DRUM_SEQ_SWING_EN
    task automatic test_swing();
        logic       exp_strobe;
        logic [3:0] exp_idx;
        swing = 8'd128;
        step_len = 8;
        gate_len = 1;
        run = 1'b1;
        cyc(1'b0);
        for (int k = 0; k <= 32; k++) begin
            cyc(1'b1);
            exp_strobe = (k == 0 || k == 12 || k == 16 || k == 28 || k == 32);
            exp_idx = (k >= 32) ? 4'd4 : (k >= 28) ? 4'd3 : (k >= 16) ? 4'd2 : (k >= 12) ? 4'd1 : 4'd0;
            vec_cnt++;
            if (step_strobe !== exp_strobe) begin err_cnt++; $display("FAIL swing_strobe k=%0d got %b exp %b", k, step_strobe, exp_strobe); end
            vec_cnt++;
            if (step_idx !== exp_idx) begin err_cnt++; $display("FAIL swing_idx k=%0d got %0d exp %0d", k, step_idx, exp_idx); end
            cyc(1'b0);
        end
        run = 1'b0;
        swing = 8'd0;
        cyc(1'b0);
    endtask
`endif

    task automatic test_async_reset();
        write_row(0, 4'b1111);
        step_len = 1;
        gate_len = 5;
        run = 1'b1;
        cyc(1'b0);
        cyc(1'b1);
        vec_cnt++;
        if (trig_out !== 4'b1111) begin err_cnt++; $display("FAIL areset_pre_trig got %b exp 1111", trig_out); end
        cyc(1'b1);
        vec_cnt++;
        if (step_idx !== 4'd1) begin err_cnt++; $display("FAIL areset_pre_idx got %0d exp 1", step_idx); end
        #2;
        rst = 1'b1;
        #1;
        vec_cnt++;
        if (trig_out !== 4'b0000) begin err_cnt++; $display("FAIL areset_trig got %b exp 0000", trig_out); end
        vec_cnt++;
        if (step_idx !== 4'd0) begin err_cnt++; $display("FAIL areset_idx got %0d exp 0", step_idx); end
        vec_cnt++;
        if (step_strobe !== 1'b0) begin err_cnt++; $display("FAIL areset_strobe got %b exp 0", step_strobe); end
        vec_cnt++;
        if (seq_state !== 2'd0) begin err_cnt++; $display("FAIL areset_state got %0d exp 0", seq_state); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b0);
        vec_cnt++;
        if (trig_out !== 4'b0000) begin err_cnt++; $display("FAIL areset_release_trig got %b exp 0000", trig_out); end
        cyc(1'b1);
        vec_cnt++;
        if (step_strobe !== 1'b1) begin err_cnt++; $display("FAIL areset_refire_strobe got %b exp 1", step_strobe); end
        vec_cnt++;
        if (trig_out !== 4'b0000) begin err_cnt++; $display("FAIL areset_pattern_cleared got %b exp 0000", trig_out); end
        run = 1'b0;
        cyc(1'b0);
    endtask

    initial begin
        cfg_if.cfg_we      = 1'b0;
        cfg_if.cfg_step    = '0;
        cfg_if.cfg_pattern = '0;
        test_reset();
        test_pattern();
        test_retrigger();
        test_manual();
        test_run_drop();
        test_zero_len();
        test_len_change();
`ifdef DRUM_SEQ_SWING_EN
        test_swing();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
